kanagawa_hal_reset_sequencer: RTL

Sequences reset release across NUM_STAGES dependent reset domains after the board/PLL reset deasserts. Examples: clocking, memory controller, datapath, host interface. Stages are released strictly in index order. The next stage is released only after the previous stage acknowledges ready and a programmable gap elapses. A soft reset request re-runs the sequence. Sits between the per-clock reset synchronizers and the domain logic.

---
 rtl/kanagawa_reset_seq_pkg.sv | 36 +++
 rtl/kanagawa_reset_seq_down_counter.sv | 39 +++
 rtl/kanagawa_hal_reset_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/kanagawa_reset_seq_pkg.sv
// kanagawa_reset_seq_pkg
//   Shared types and helpers for the reset sequencer slice.
//   - seq_state_t : sequencer FSM states
//   - DEF_*       : default parameter values for the top level
//   - cnt_width   : width of the shared hold/gap/timeout counters
//   - idx_width   : width of the stage index (minimum 1)
package kanagawa_reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      RELEASE,
      WAIT_ACK,
      GAP,
      RUN,
      FAULT
   } seq_state_t;

   localparam int DEF_NUM_STAGES     = 4;
   localparam int DEF_HOLD_CYCLES    = 16;
   localparam int DEF_STAGE_GAP      = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // Wide enough to hold the largest value any counter is ever loaded with.
   function automatic int cnt_width(input int hold, input int gap, input int tmo);
      int m;
      m = hold;
      if (gap > m) m = gap;
      if (tmo > m) m = tmo;
      return $clog2(m + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/kanagawa_reset_seq_down_counter.sv
// kanagawa_reset_seq_down_counter
//   Loadable down-counter that saturates at zero.
//   Ports:
//     clk      : clock
//     arst_n   : asynchronous active-low clear (count returns to RST_VAL)
//     load     : load load_val (has priority over en)
//     load_val : value to load
//     en       : decrement by one when nonzero
//     zero     : count is 0
//     at_one   : count is 1, i.e. the next enabled cycle reaches 0
module kanagawa_reset_seq_down_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero,
   output logic             at_one
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero   = (count == '0);
   assign at_one = (count == WIDTH'(1));

endmodule

// File: rtl/kanagawa_hal_reset_sequencer.sv
// kanagawa_hal_reset_sequencer
//   Releases NUM_STAGES dependent reset domains in index order once the
//   board/PLL reset deasserts. Each stage is released only after the
//   previous one acknowledges and STAGE_GAP cycles elapse. A soft request,
//   or any ack dropping while running, re-runs the whole sequence.
//   Optional ack timeout: define KANAGAWA_RESET_SEQ_TIMEOUT_EN.
//   Ports:
//     clk          : clock
//     arst_n       : asynchronous active-low reset
//     soft_rst_req : single-cycle request to restart the sequence
//     stage_ack    : per-stage ready (already synchronized to clk)
//     stage_rst    : per-stage active-high reset, registered
//     all_released : every stage released and acked
//     busy         : sequencer is not in RUN
//     timeout_err  : sticky ack-timeout flag (0 when the timeout is not built)
module kanagawa_hal_reset_sequencer
   import kanagawa_reset_seq_pkg::*;
#(
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int STAGE_GAP      = DEF_STAGE_GAP,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  soft_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  all_released,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, TIMEOUT_CYCLES);
   localparam int IDX_W = idx_width(NUM_STAGES);

   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(STAGE_GAP);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   seq_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic             ack_cur;
   logic             restart;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_en;
   logic             cnt_zero;
   logic             cnt_at_one;
   logic             cnt_done;
   logic             tmo_expire;

   assign idx_nxt = idx + IDX_W'(1);
   // Only the ack of the stage currently being waited on matters.
   assign ack_cur = stage_ack[idx];
   // A dropped ack while running is handled exactly like a soft request.
   assign restart = soft_rst_req || ((state == RUN) && !(&stage_ack));
   // Counting down from N: the Nth enabled edge is the one that reaches 0.
   assign cnt_done = cnt_at_one || cnt_zero;

   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = HOLD_LD;
      cnt_en       = 1'b0;
      if (restart) begin
         cnt_load = 1'b1;
      end else if ((state == WAIT_ACK) && ack_cur && (idx != LAST_IDX)) begin
         cnt_load     = 1'b1;
         cnt_load_val = GAP_LD;
      end else if ((state == HOLD) || (state == GAP)) begin
         cnt_en = 1'b1;
      end
   end

   kanagawa_reset_seq_down_counter #(
      .WIDTH   (CNT_W),
      .RST_VAL (HOLD_LD)
   ) u_hold_gap_cnt (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .zero     (cnt_zero),
      .at_one   (cnt_at_one)
   );

`ifdef KANAGAWA_RESET_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TIMEOUT_CYCLES);

   logic tmo_zero;
   logic tmo_at_one;

   // Loaded while in RELEASE so it is full on the first WAIT_ACK cycle.
   kanagawa_reset_seq_down_counter #(
      .WIDTH   (CNT_W),
      .RST_VAL (TMO_LD)
   ) u_timeout_cnt (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (state == RELEASE),
      .load_val (TMO_LD),
      .en       (state == WAIT_ACK),
      .zero     (tmo_zero),
      .at_one   (tmo_at_one)
   );

   // An ack in the expiry cycle wins, and so does a restart.
   assign tmo_expire = (state == WAIT_ACK) && !ack_cur && !restart &&
                       (tmo_at_one || tmo_zero);

   // Sticky until arst_n; a soft restart deliberately leaves it set.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         timeout_err <= 1'b0;
      end else if (tmo_expire) begin
         timeout_err <= 1'b1;
      end
   end
`else
   assign tmo_expire  = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // The release of stage idx is issued on the edge that enters RELEASE, so
   // stage_rst[0] falls exactly HOLD_CYCLES edges after arst_n deasserts.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state        <= HOLD;
         idx          <= '0;
         stage_rst    <= '1;
         all_released <= 1'b0;
         busy         <= 1'b1;
      end else if (restart) begin
         state        <= HOLD;
         idx          <= '0;
         stage_rst    <= '1;
         all_released <= 1'b0;
         busy         <= 1'b1;
      end else begin
         case (state)
            HOLD: begin
               if (cnt_done) begin
                  state          <= RELEASE;
                  stage_rst[idx] <= 1'b0;
               end
            end
            RELEASE: begin
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (ack_cur) begin
                  if (idx == LAST_IDX) begin
                     state        <= RUN;
                     all_released <= 1'b1;
                     busy         <= 1'b0;
                  end else if (STAGE_GAP == 0) begin
                     state              <= RELEASE;
                     idx                <= idx_nxt;
                     stage_rst[idx_nxt] <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end else if (tmo_expire) begin
                  state     <= FAULT;
                  stage_rst <= '1;
               end
            end
            GAP: begin
               if (cnt_done) begin
                  state              <= RELEASE;
                  idx                <= idx_nxt;
                  stage_rst[idx_nxt] <= 1'b0;
               end
            end
            RUN: begin
               state <= RUN;
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state <= HOLD;
            end
         endcase
      end
   end

endmodule
